simmem_bank_timing: RTL and testbench

Parametrised multi-bank row-buffer timing model for the simulated memory controller. Each request carries an address and an ID. The block finds the target bank and charges row-hit, activation and precharge costs from that bank's open-row state, then returns the ID with its computed delay once the modelled access has finished. It sits between the request scheduler and the response banks. It generalises the fixed single-row cost constants to N independent banks with a per-request open/closed page policy.

---
 rtl/simmem_bank_timing.sv | 225 ++++++++++++++++++++++
 tb/tb_simmem_bank_timing.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/simmem_bank_timing.sv
// Multi-bank row-buffer timing model: per-bank PRE/ACT/ACC sequencing with open-row tracking,
// round-robin completion arbitration across banks.
module simmem_bank_timing #(
  parameter int unsigned NumBanks       = 4,
  parameter int unsigned AddrW          = 16,
  parameter int unsigned RowBufLenW     = 8,
  parameter int unsigned IdW            = 2,
  parameter int unsigned RowHitCost     = 4,
  parameter int unsigned PrechargeCost  = 2,
  parameter int unsigned ActivationCost = 1,
  parameter int unsigned DelayW         = 6
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [AddrW-1:0]  req_addr_i,
  input  logic [IdW-1:0]    req_id_i,
  input  logic              req_close_page_i,
  output logic              done_valid_o,
  input  logic              done_ready_i,
  output logic [IdW-1:0]    done_id_o,
  output logic              done_row_hit_o,
  output logic [DelayW-1:0] done_delay_o
);

  localparam int unsigned BankW = $clog2(NumBanks);
  localparam int unsigned RowW  = AddrW - RowBufLenW - BankW;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StPre  = 3'd1;
  localparam logic [2:0] StAct  = 3'd2;
  localparam logic [2:0] StAcc  = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  localparam logic [DelayW-1:0] PreCnt = DelayW'(PrechargeCost - 1);
  localparam logic [DelayW-1:0] ActCnt = DelayW'(ActivationCost - 1);
  localparam logic [DelayW-1:0] HitCnt = DelayW'(RowHitCost - 1);
  localparam logic [DelayW-1:0] DlyHit = DelayW'(RowHitCost);
  localparam logic [DelayW-1:0] DlyAct = DelayW'(ActivationCost + RowHitCost);
  localparam logic [DelayW-1:0] DlyPre = DelayW'(PrechargeCost + ActivationCost + RowHitCost);

  logic [2:0]        bank_state_q [NumBanks];
  logic [2:0]        bank_state_d [NumBanks];
  logic [DelayW-1:0] cnt_q        [NumBanks];
  logic [DelayW-1:0] cnt_d        [NumBanks];
  logic [IdW-1:0]    id_q         [NumBanks];
  logic [IdW-1:0]    id_d         [NumBanks];
  logic              row_open_q   [NumBanks];
  logic              row_open_d   [NumBanks];
  logic [RowW-1:0]   open_row_q   [NumBanks];
  logic [RowW-1:0]   open_row_d   [NumBanks];
  logic [RowW-1:0]   req_row_q    [NumBanks];
  logic [RowW-1:0]   req_row_d    [NumBanks];
  logic              close_q      [NumBanks];
  logic              close_d      [NumBanks];
  logic              hit_q        [NumBanks];
  logic              hit_d        [NumBanks];
  logic [DelayW-1:0] delay_q      [NumBanks];
  logic [DelayW-1:0] delay_d      [NumBanks];

  logic [BankW-1:0] rr_q, rr_d;
  logic             lock_q, lock_d;
  logic [BankW-1:0] lock_idx_q, lock_idx_d;

  logic [BankW-1:0] req_bank;
  logic [RowW-1:0]  req_row;
  logic             accept;
  logic [BankW-1:0] arb_idx;
  logic [BankW-1:0] arb_pick;
  logic             arb_found;
  logic [BankW-1:0] grant;
  logic             pop;
  logic             unused_addr;

  assign req_bank    = req_addr_i[RowBufLenW +: BankW];
  assign req_row     = req_addr_i[AddrW-1 -: RowW];
  assign unused_addr = ^req_addr_i[RowBufLenW-1:0];
  assign req_ready_o = (bank_state_q[req_bank] == StIdle);
  assign accept      = req_valid_i & req_ready_o;

  // First DONE bank at or after the round-robin pointer.
  always_comb begin
    arb_pick  = rr_q;
    arb_found = 1'b0;
    arb_idx   = rr_q;
    for (int i = 0; i < NumBanks; i++) begin
      arb_idx = rr_q + BankW'(i);
      if (!arb_found && bank_state_q[arb_idx] == StDone) begin
        arb_pick  = arb_idx;
        arb_found = 1'b1;
      end
    end
  end

  // Once offered, a completion stays locked until popped so stalled outputs never change.
  assign grant        = lock_q ? lock_idx_q : arb_pick;
  assign done_valid_o = lock_q | arb_found;
  assign pop          = done_valid_o & done_ready_i;

  assign done_id_o      = done_valid_o ? id_q[grant]    : '0;
  assign done_row_hit_o = done_valid_o ? hit_q[grant]   : 1'b0;
  assign done_delay_o   = done_valid_o ? delay_q[grant] : '0;

  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    rr_d       = rr_q;
    if (pop) begin
      lock_d = 1'b0;
      rr_d   = grant + BankW'(1);
    end else if (done_valid_o) begin
      lock_d     = 1'b1;
      lock_idx_d = grant;
    end
  end

  always_comb begin
    for (int b = 0; b < NumBanks; b++) begin
      bank_state_d[b] = bank_state_q[b];
      cnt_d[b]        = cnt_q[b];
      id_d[b]         = id_q[b];
      row_open_d[b]   = row_open_q[b];
      open_row_d[b]   = open_row_q[b];
      req_row_d[b]    = req_row_q[b];
      close_d[b]      = close_q[b];
      hit_d[b]        = hit_q[b];
      delay_d[b]      = delay_q[b];
      case (bank_state_q[b])
        StIdle: begin
          if (accept && req_bank == BankW'(b)) begin
            id_d[b]      = req_id_i;
            close_d[b]   = req_close_page_i;
            req_row_d[b] = req_row;
            if (row_open_q[b] && open_row_q[b] == req_row) begin
              bank_state_d[b] = StAcc;
              cnt_d[b]        = HitCnt;
              hit_d[b]        = 1'b1;
              delay_d[b]      = DlyHit;
            end else if (!row_open_q[b]) begin
              bank_state_d[b] = StAct;
              cnt_d[b]        = ActCnt;
              hit_d[b]        = 1'b0;
              delay_d[b]      = DlyAct;
            end else begin
              bank_state_d[b] = StPre;
              cnt_d[b]        = PreCnt;
              hit_d[b]        = 1'b0;
              delay_d[b]      = DlyPre;
            end
          end
        end
        StPre: begin
          if (cnt_q[b] == '0) begin
            bank_state_d[b] = StAct;
            cnt_d[b]        = ActCnt;
          end else begin
            cnt_d[b] = cnt_q[b] - DelayW'(1);
          end
        end
        StAct: begin
          if (cnt_q[b] == '0) begin
            bank_state_d[b] = StAcc;
            cnt_d[b]        = HitCnt;
            row_open_d[b]   = 1'b1;
            open_row_d[b]   = req_row_q[b];
          end else begin
            cnt_d[b] = cnt_q[b] - DelayW'(1);
          end
        end
        StAcc: begin
          if (cnt_q[b] == '0) begin
            bank_state_d[b] = StDone;
            if (close_q[b]) begin
              row_open_d[b] = 1'b0;
            end
          end else begin
            cnt_d[b] = cnt_q[b] - DelayW'(1);
          end
        end
        StDone: begin
          if (pop && grant == BankW'(b)) begin
            bank_state_d[b] = StIdle;
          end
        end
        default: bank_state_d[b] = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      for (int b = 0; b < NumBanks; b++) begin
        bank_state_q[b] <= StIdle;
        cnt_q[b]        <= '0;
        id_q[b]         <= '0;
        row_open_q[b]   <= 1'b0;
        open_row_q[b]   <= '0;
        req_row_q[b]    <= '0;
        close_q[b]      <= 1'b0;
        hit_q[b]        <= 1'b0;
        delay_q[b]      <= '0;
      end
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      for (int b = 0; b < NumBanks; b++) begin
        bank_state_q[b] <= bank_state_d[b];
        cnt_q[b]        <= cnt_d[b];
        id_q[b]         <= id_d[b];
        row_open_q[b]   <= row_open_d[b];
        open_row_q[b]   <= open_row_d[b];
        req_row_q[b]    <= req_row_d[b];
        close_q[b]      <= close_d[b];
        hit_q[b]        <= hit_d[b];
        delay_q[b]      <= delay_d[b];
      end
    end
  end

endmodule

// File: tb/tb_simmem_bank_timing.sv
// Directed bench for simmem_bank_timing with default parameters (4 banks, costs 4/2/1).
module tb_simmem_bank_timing;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StPre  = 3'd1;
  localparam logic [2:0] StAct  = 3'd2;
  localparam logic [2:0] StAcc  = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [15:0] req_addr_i;
  logic [1:0]  req_id_i;
  logic        req_close_page_i;
  logic        done_valid_o;
  logic        done_ready_i;
  logic [1:0]  done_id_o;
  logic        done_row_hit_o;
  logic [5:0]  done_delay_o;

  int checks = 0;
  int errors = 0;

  simmem_bank_timing dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_addr_i       (req_addr_i),
    .req_id_i         (req_id_i),
    .req_close_page_i (req_close_page_i),
    .done_valid_o     (done_valid_o),
    .done_ready_i     (done_ready_i),
    .done_id_o        (done_id_o),
    .done_row_hit_o   (done_row_hit_o),
    .done_delay_o     (done_delay_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Presents a request, waits (bounded) for ready, and returns 1 time unit after the accept edge.
  task automatic send(input logic [15:0] a, input logic [1:0] id, input logic c);
    int k = 0;
    req_addr_i       = a;
    req_id_i         = id;
    req_close_page_i = c;
    req_valid_i      = 1'b1;
    #1;
    while (req_ready_o !== 1'b1 && k < 60) begin
      tick();
      k++;
    end
    check("send_ready", {31'd0, req_ready_o}, 32'd1);
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
  endtask

  // Waits for done_valid_o; lat < 0 skips the latency comparison.
  task automatic wait_done(input string tag, input int lat, input logic [1:0] id,
                           input logic hit, input logic [5:0] dly);
    int k = 0;
    while (done_valid_o !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    check({tag, "_valid"}, {31'd0, done_valid_o}, 32'd1);
    if (lat >= 0) check({tag, "_lat"}, k, lat);
    check({tag, "_id"}, {30'd0, done_id_o}, {30'd0, id});
    check({tag, "_hit"}, {31'd0, done_row_hit_o}, {31'd0, hit});
    check({tag, "_delay"}, {26'd0, done_delay_o}, {26'd0, dly});
  endtask

  task automatic pop();
    done_ready_i = 1'b1;
    tick();
    done_ready_i = 1'b0;
  endtask

  logic [2:0] pre_seq [8];
  int k;

  initial begin
    pre_seq = '{StPre, StPre, StAct, StAcc, StAcc, StAcc, StAcc, StDone};
    rst_ni           = 1'b0;
    req_valid_i      = 1'b0;
    req_addr_i       = 16'h0000;
    req_id_i         = 2'd0;
    req_close_page_i = 1'b0;
    done_ready_i     = 1'b0;

    // Reset values
    #12;
    check("rst_valid", {31'd0, done_valid_o}, 32'd0);
    check("rst_ready", {31'd0, req_ready_o}, 32'd1);
    check("rst_id", {30'd0, done_id_o}, 32'd0);
    check("rst_hit", {31'd0, done_row_hit_o}, 32'd0);
    check("rst_delay", {26'd0, done_delay_o}, 32'd0);
    #5 rst_ni = 1'b1;
    tick();

    // Cold access then row hit
    send(16'h0400, 2'd1, 1'b0);
    wait_done("cold", 5, 2'd1, 1'b0, 6'd5);
    pop();
    check("cold_popped", {31'd0, done_valid_o}, 32'd0);
    send(16'h0400, 2'd2, 1'b0);
    wait_done("hit", 4, 2'd2, 1'b1, 6'd4);
    pop();

    // Row conflict: bank 0 row 1 open, row 2 requested
    send(16'h0800, 2'd3, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("conf_state%0d", i), {29'd0, dut.bank_state_q[0]}, {29'd0, pre_seq[i]});
      if (i < 7) tick();
    end
    wait_done("conf", 0, 2'd3, 1'b0, 6'd7);
    pop();

    // Closed page: row closed after the access, next one is a cold activation
    send(16'h0400, 2'd0, 1'b1);
    wait_done("close1", 7, 2'd0, 1'b0, 6'd7);
    pop();
    send(16'h0400, 2'd1, 1'b1);
    wait_done("close2", 5, 2'd1, 1'b0, 6'd5);
    pop();

    // Concurrency: three cold banks, stalled completion, then round-robin drain
    send(16'h0000, 2'd1, 1'b0);
    send(16'h0100, 2'd2, 1'b0);
    send(16'h0200, 2'd3, 1'b0);
    wait_done("conc0", 3, 2'd1, 1'b0, 6'd5);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_valid", {31'd0, done_valid_o}, 32'd1);
      check("stall_id", {30'd0, done_id_o}, 32'd1);
      check("stall_delay", {26'd0, done_delay_o}, 32'd5);
    end
    done_ready_i = 1'b1;
    tick();
    check("rr1_id", {30'd0, done_id_o}, 32'd2);
    check("rr1_valid", {31'd0, done_valid_o}, 32'd1);
    tick();
    check("rr2_id", {30'd0, done_id_o}, 32'd3);
    check("rr2_valid", {31'd0, done_valid_o}, 32'd1);
    tick();
    check("rr_empty", {31'd0, done_valid_o}, 32'd0);
    done_ready_i = 1'b0;

    // Busy bank stall: 0x0800 waits for bank 0, 0x0500 (bank 1) waits behind it
    send(16'h0400, 2'd0, 1'b0);
    req_addr_i  = 16'h0800;
    req_id_i    = 2'd1;
    req_valid_i = 1'b1;
    #1;
    k = 0;
    while (done_valid_o !== 1'b1 && k < 40) begin
      check("busy_ready", {31'd0, req_ready_o}, 32'd0);
      check("busy_bank1", {29'd0, dut.bank_state_q[1]}, {29'd0, StIdle});
      tick();
      k++;
    end
    check("busy_wait", k, 7);
    check("busy_done_id", {30'd0, done_id_o}, 32'd0);
    check("busy_done_delay", {26'd0, done_delay_o}, 32'd7);
    check("busy_ready_done", {31'd0, req_ready_o}, 32'd0);
    done_ready_i = 1'b1;
    tick();
    done_ready_i = 1'b0;
    check("busy_ready_after_pop", {31'd0, req_ready_o}, 32'd1);
    check("busy_no_bypass", {29'd0, dut.bank_state_q[0]}, {29'd0, StIdle});
    tick();
    req_valid_i = 1'b0;
    check("busy_accepted", {29'd0, dut.bank_state_q[0]}, {29'd0, StPre});
    send(16'h0500, 2'd2, 1'b0);
    wait_done("busy_b0", 6, 2'd1, 1'b0, 6'd7);
    pop();
    wait_done("busy_b1", 0, 2'd2, 1'b0, 6'd7);
    pop();

    // Reset mid-operation discards requests and open rows
    send(16'h0400, 2'd3, 1'b0);
    send(16'h0100, 2'd2, 1'b0);
    tick();
    #2 rst_ni = 1'b0;
    #1;
    check("mrst_valid", {31'd0, done_valid_o}, 32'd0);
    check("mrst_ready", {31'd0, req_ready_o}, 32'd1);
    check("mrst_bank0", {29'd0, dut.bank_state_q[0]}, {29'd0, StIdle});
    tick();
    #3 rst_ni = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("mrst_quiet", {31'd0, done_valid_o}, 32'd0);
    end
    send(16'h0400, 2'd1, 1'b0);
    wait_done("mrst_cold", 5, 2'd1, 1'b0, 6'd5);
    pop();
    check("mrst_end", {31'd0, done_valid_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
